unified_mem_responder: RTL



---
 rtl/unified_mem_responder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/unified_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : unified_mem_responder
// Description : Unified instruction/data memory responder with programmable
//               wait states and a one-cycle ready pulse per access.
//               Optional alignment checking via `MEMRESP_ALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module unified_mem_responder #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ready,
    output logic                  busy,
    output logic                  err
);

    localparam logic [1:0] C_IDLE  = 2'd0;
    localparam logic [1:0] C_BUSY  = 2'd1;
    localparam logic [1:0] C_RESP  = 2'd2;
    localparam int         C_DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] C_WAIT  = 4'(WAIT_STATES);

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q,   cnt_d;
    logic                  we_q,    we_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q,   err_d;

    logic [DATA_WIDTH-1:0] mem [C_DEPTH];
    logic [DEPTH_LOG2-1:0] index;
    logic                  range_err;
    logic                  align_err;
    logic                  acc_err;
    logic                  mem_write;

    assign index     = addr_q[DEPTH_LOG2+1:2];
    assign range_err = (addr_q >> (DEPTH_LOG2 + 2)) != '0;

`ifdef MEMRESP_ALIGN_CHECK_EN
    assign align_err = addr_q[1:0] != 2'b00;
`else
    // Byte offset is ignored: misaligned addresses hit the containing word.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^addr_q[1:0];
    assign align_err       = 1'b0;
`endif

    assign acc_err   = range_err | align_err;
    assign mem_write = (state_q == C_BUSY) && (cnt_q == 4'd0) && we_q && !acc_err;

    // State and captured-request registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= C_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (mem_write) begin
            mem[index] <= wdata_q;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            C_IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = C_WAIT;
                    err_d   = 1'b0;
                    state_d = C_BUSY;
                end
            end
            C_BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    err_d   = acc_err;
                    state_d = C_RESP;
                    if (!we_q) begin
                        rdata_d = acc_err ? '0 : mem[index];
                    end
                end
            end
            C_RESP:  state_d = C_IDLE;
            default: state_d = C_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ready = (state_q == C_RESP);
        busy  = (state_q != C_IDLE);
        err   = (state_q == C_RESP) && err_q;
        rdata = rdata_q;
    end

endmodule
`default_nettype wire
